sseg_dev: RTL and testbench

Serial driver for the board's eight-digit seven-segment display. Converts a 32-bit hex word plus per-digit decimal-point and blink masks into a 64-bit active-low segment frame. On each rising edge of `Start`, it shifts the frame out MSB-first over a clock/data/clear/enable interface to the external shift-register chain. The top level uses it to show score and health; it is independent of the VGA picture ROMs.

---
 rtl/sseg_dev.sv | 145 ++++++++++++++
 tb/tb_sseg_dev.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_dev.sv
// Serial driver for the eight-digit seven-segment display. It builds a 64-bit
// active-low segment frame and shifts it MSB-first to an external register chain.
module sseg_dev (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        flash,
    input  logic [31:0] Hexs,
    input  logic [7:0]  point,
    input  logic [7:0]  LES,
    output logic        seg_clk,
    output logic        seg_clrn,
    output logic        seg_sout,
    output logic        SEG_PEN
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_start_q;
    logic [63:0] r_frame;
    logic [5:0]  r_bit_cnt;
    logic        r_phase;
    logic        r_seg_clk;
    logic        r_seg_pen;
    logic        w_start_edge;
    logic        w_load;
    logic        w_finish;
    logic        w_last_bit;
    logic [63:0] w_frame;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Blanked digits turn everything off, decimal point included.
    function automatic logic [7:0] digit_byte(input logic [3:0] hex, input logic dp,
                                              input logic blank);
        logic [7:0] byte_v;
        if (blank)
            byte_v = 8'hFF;
        else
            byte_v = ~{dp, hex_to_seg(hex)};
        return byte_v;
    endfunction

    always_comb begin
        w_frame = '1;
        for (int i = 0; i < 8; i++)
            w_frame[8*i +: 8] = digit_byte(Hexs[4*i +: 4], point[i], LES[i] & ~flash);
    end

    assign w_start_edge = Start & ~r_start_q;
    assign w_last_bit   = (r_bit_cnt == 6'd63);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (r_phase && w_last_bit) begin
                    w_state_nxt = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // The frame shifts left with ones filling in, so its MSB is the serial
    // output and drains to 1 by itself once the last bit has gone out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q <= 1'b0;
            r_frame   <= '1;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_seg_clk <= 1'b0;
            r_seg_pen <= 1'b0;
        end else begin
            r_start_q <= Start;
            if (w_load) begin
                r_frame   <= w_frame;
                r_bit_cnt <= '0;
                r_phase   <= 1'b0;
                r_seg_clk <= 1'b0;
                r_seg_pen <= 1'b0;
            end else if (r_state == SHIFT) begin
                if (!r_phase) begin
                    r_seg_clk <= 1'b1;
                    r_phase   <= 1'b1;
                end else begin
                    r_seg_clk <= 1'b0;
                    r_phase   <= 1'b0;
                    r_frame   <= {r_frame[62:0], 1'b1};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (w_finish)
                        r_seg_pen <= 1'b1;
                end
            end
        end
    end

    assign seg_clk  = r_seg_clk;
    assign seg_sout = r_frame[63];
    assign SEG_PEN  = r_seg_pen;
    assign seg_clrn = rst;

endmodule

// File: tb/tb_sseg_dev.sv
// Scoreboard bench for sseg_dev: each Start edge queues the expected frame, and a
// monitor rebuilds frames from seg_clk/seg_sout and compares them.
module tb_sseg_dev;
    logic        clk;
    logic        rst;
    logic        Start;
    logic        flash;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        seg_clk;
    logic        seg_clrn;
    logic        seg_sout;
    logic        SEG_PEN;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] sb_q[$];
    logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sseg_dev dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .flash    (flash),
        .Hexs     (Hexs),
        .point    (point),
        .LES      (LES),
        .seg_clk  (seg_clk),
        .seg_clrn (seg_clrn),
        .seg_sout (seg_sout),
        .SEG_PEN  (SEG_PEN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] h, input logic [7:0] p,
                                          input logic [7:0] l, input logic f);
        logic [63:0] fr;
        for (int i = 0; i < 8; i++) begin
            if (l[i] && !f)
                fr[8*i +: 8] = 8'hFF;
            else
                fr[8*i +: 8] = ~{p[i], seg_tbl[h[4*i +: 4]]};
        end
        return fr;
    endfunction

    // Monitor: collect one bit per seg_clk rising edge; every 64 bits form a frame.
    int          mon_bits  = 0;
    int          mon_rises = 0;
    logic [63:0] mon_sh    = '0;
    logic [63:0] mon_exp;
    logic        mon_prev  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            mon_bits = 0;
            mon_prev = 1'b0;
        end else begin
            if (seg_clk && !mon_prev) begin
                mon_sh = {mon_sh[62:0], seg_sout};
                mon_bits++;
                mon_rises++;
                if (mon_bits == 64) begin
                    mon_bits = 0;
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_frame got=%h required=none", mon_sh);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        chk("frame", mon_sh, mon_exp);
                    end
                end
            end
            mon_prev = seg_clk;
        end
    end

    // mode 0: plain frame; 1: Start pulses and input changes mid-frame; 2: Start held high.
    task automatic run_frame(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                             input logic f, input int mode, input bit rel);
        logic [63:0] ef;
        int          cyc;
        int          r0;
        @(negedge clk);
        Hexs  = h;
        point = p;
        LES   = l;
        flash = f;
        Start = 1'b1;
        if (rel) rst = 1'b1;
        ef = model(h, p, l, f);
        sb_q.push_back(ef);
        r0 = mon_rises;
        @(posedge clk); #1;
        chk("load_pen", SEG_PEN, 0);
        chk("load_sout", seg_sout, ef[63]);
        chk("load_clk", seg_clk, 0);
        chk("clrn_high", seg_clrn, 1);
        cyc = 0;
        while (SEG_PEN !== 1'b1 && cyc < 300) begin
            if (mode != 2 && cyc == 2) Start = 1'b0;
            if (mode == 1 && cyc == 30) begin
                Hexs  = $urandom;
                point = 8'($urandom);
                LES   = 8'($urandom);
                flash = ~flash;
                Start = 1'b1;
            end
            if (mode == 1 && cyc == 34) Start = 1'b0;
            if (mode == 1 && cyc == 90) Start = 1'b1;
            if (mode == 1 && cyc == 95) Start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("pen_low_cycles", cyc, 128);
        chk("end_clk", seg_clk, 0);
        chk("end_sout", seg_sout, 1);
        chk("frame_delivered", sb_q.size(), 0);
        if (mode == 2) repeat (30) begin @(posedge clk); #1; end
        Start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("rises_per_frame", mon_rises - r0, 64);
        chk("pen_held", SEG_PEN, 1);
    endtask

    initial begin
        int r0;
        rst   = 1'b0;
        Start = 1'b0;
        flash = 1'b1;
        Hexs  = '0;
        point = '0;
        LES   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk", seg_clk, 0);
        chk("rst_clrn", seg_clrn, 0);
        chk("rst_sout", seg_sout, 1);
        chk("rst_pen", SEG_PEN, 0);

        // Start already high at the first clock after release counts as an edge.
        Start = 1'b1;
        run_frame(32'h0000_0000, 8'h00, 8'h00, 1'b1, 0, 1'b1);
        run_frame(32'h0A00_0003, 8'b0100_0001, 8'h00, 1'b1, 0, 1'b0);
        run_frame(32'h1234_5678, 8'h00, 8'h0F, 1'b0, 0, 1'b0);
        run_frame(32'h1234_5678, 8'h00, 8'h0F, 1'b1, 0, 1'b0);
        run_frame(32'hDEAD_BEEF, 8'h81, 8'h00, 1'b1, 1, 1'b0);
        run_frame(32'h9876_5432, 8'h10, 8'hF0, 1'b0, 2, 1'b0);

        // Reset in the middle of a frame, right after bit 20 goes out.
        @(negedge clk);
        Hexs  = 32'hCAFE_F00D;
        point = 8'h00;
        LES   = 8'h00;
        Start = 1'b1;
        sb_q.push_back(model(Hexs, point, LES, flash));
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("bits_before_reset", mon_bits, 20);
        rst = 1'b0;
        #1;
        chk("midrst_clrn", seg_clrn, 0);
        chk("midrst_pen", SEG_PEN, 0);
        chk("midrst_clk", seg_clk, 0);
        chk("midrst_sout", seg_sout, 1);
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        r0  = mon_rises;
        repeat (200) begin @(posedge clk); #1; end
        chk("no_clk_after_reset", mon_rises - r0, 0);
        chk("pen_after_reset", SEG_PEN, 0);
        chk("sout_after_reset", seg_sout, 1);

        for (int k = 0; k < 12; k++)
            run_frame($urandom, 8'($urandom), 8'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), 1'b0);

        chk("no_partial_frame", mon_bits, 0);
        chk("queue_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
